alu_seq_ctrl: RTL and testbench
===============================

Name: alu_seq_ctrl

Overview:
Multi-cycle ALU sequencer for the 16-bit datapath. A single shared add16bits adder performs ADD, SUB, NEG, ABS and unsigned MUL. SUB, NEG and ABS use the invert-plus-one negation path. Operations enter through a valid/ready request port and results leave through a valid/ready response port; the block sits between the lab top-level/operand registers and the adder.

Parameters:
WIDTH, 16, datapath width; fixed at 16 to match add16bits, not overridable.
MUL_CYCLES, 16, shift-add iterations for MUL; equals WIDTH.

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  synchronous active-low reset
op_valid  input  1  request valid
op_ready  output  1  request accepted when op_valid & op_ready at clk edge
op_code  input  3  000 ADD, 001 SUB, 010 NEG, 011 ABS, 100 MUL, others illegal
a_in  input  16  operand A, sampled on accept
b_in  input  16  operand B, sampled on accept; ignored for NEG/ABS
res_valid  output  1  result valid
res_ready  input  1  result consumed when res_valid & res_ready at clk edge
result  output  16  result
overflow  output  1  signed overflow for ADD/SUB/NEG/ABS; unsigned overflow for MUL
zero  output  1  result == 0
err  output  1  illegal opcode flag

Behaviour:
- Reset: clk and rst_n only; synchronous, active-low. rst_n low at an edge forces state IDLE and clears result, overflow, zero, err, res_valid, and all internal operand, accumulator and counter registers. This applies from any state, including mid-MUL; no partial result survives. op_ready decodes state == IDLE, so it reads 1 in the first cycle after release.
- States:
  - IDLE: op_ready=1. On accept, latch op_code, a and b, then go to EXEC, or MUL when op_code=100.
  - EXEC (1 cycle): perform one adder pass.
    - ADD: sum = a+b.
    - NEG: sum = ~a+1.
    - ABS: a[15] ? ~a+1 : a.
    - SUB pass 1: nb = ~b+1, then go to EXEC2.
    - Illegal opcode: result 0, err=1.
    - Go to DONE unless SUB.
  - EXEC2 (SUB only): sum = a+nb, then go to DONE.
  - MUL: 16 iterations; cnt counts 0..15.
  - DONE: res_valid=1; result, overflow, zero and err are registered and held stable. On res_ready go to IDLE.
- MUL algorithm:
  - Each iteration, if mplier[0] then acc <= acc+mcand.
  - mcand <<= 1 and mplier >>= 1.
  - lost |= mcand[15] on each shift.
  - ovf |= mplier[0] & (cout | lost).
  - cout = (x15&y15) | ((x15|y15) & ~sum15), derived from adder operands and sum.
  - After cnt=15, go to DONE.
- Latency from the accept edge to res_valid high:
  - ADD/NEG/ABS/illegal: 2 edges (EXEC, then DONE).
  - SUB: 3 edges.
  - MUL: 17 edges.
- Overflow rules:
  - ADD: a15==b15 && r15!=a15.
  - SUB: a15!=b15 && r15!=a15. Computed from the original b, so b=0x8000 is handled correctly.
  - NEG and ABS: overflow=1 only for a=0x8000, and result=0x8000.
  - MUL: sticky as defined above; result is the low 16 bits of the unsigned product.
- No new accept while not in IDLE. op_valid outside IDLE is ignored; operands need not be held after accept. Results are never dropped: DONE holds indefinitely under res_ready=0.
- Each result transaction updates all four result outputs. err clears on the next legal result.
- Adder operand muxes are driven only in EXEC, EXEC2 and MUL. In other states they are driven to 0.

Decomposition:
- Shared package alu_pkg:
  - op_code constants OP_ADD, OP_SUB, OP_NEG, OP_ABS, OP_MUL.
  - FSM state encoding.
  - WIDTH=16.
- One sub-module instance: existing add16bits (adder_u), the only adder in the block.
- Operand muxing, flag logic and the FSM stay in alu_seq_ctrl.

Test Plan:
- ADD a=0x7FFF b=0x0001 -> result 0x8000, overflow 1, zero 0, res_valid 2 edges after accept.
- SUB 0x0005-0x0007 -> 0xFFFE, overflow 0, latency 3. SUB 0x8000-0x0001 -> 0x7FFF, overflow 1. SUB 0x0000-0x8000 -> 0x8000, overflow 1.
- NEG 0x8000 -> 0x8000, overflow 1. ABS 0xFFFB -> 0x0005, overflow 0. NEG 0x0000 -> 0x0000, zero 1. op_code 111 -> result 0, err 1.
- MUL 0x00FF*0x0101 -> 0xFFFF, overflow 0, latency 17. MUL 0x0100*0x0100 -> 0x0000, overflow 1, zero 1.
- Backpressure: hold res_ready=0 for 5 cycles after ADD 0x1234+0x1111 -> result 0x2345 stable, op_ready 0, a second op_valid is ignored. Then res_ready=1 -> IDLE next edge, second op accepted afterwards.
- rst_n low at MUL iteration 8 -> next edge all outputs 0 and op_ready 1. A following ADD 1+2 returns 0x0003 with no residue from the aborted MUL.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared constants and FSM encoding for the 16-bit ALU sequencer.
package alu_pkg;

  localparam int unsigned WIDTH      = 16;
  localparam int unsigned MUL_CYCLES = WIDTH;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_NEG = 3'b010;
  localparam logic [2:0] OP_ABS = 3'b011;
  localparam logic [2:0] OP_MUL = 3'b100;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_EXEC,
    ST_EXEC2,
    ST_MUL,
    ST_DONE
  } state_e;

endpackage

// File: rtl/add16bits.sv
// Plain 16-bit adder shared by every ALU operation; carry-out is reconstructed by the caller.
module add16bits (
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic [15:0] sum
);

  assign sum = a + b;

endmodule

// File: rtl/alu_seq_ctrl.sv
// Multi-cycle ALU sequencer: ADD/SUB/NEG/ABS/MUL through one shared adder,
// valid/ready request and response ports.
module alu_seq_ctrl
  import alu_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        op_valid,
  output logic        op_ready,
  input  logic [2:0]  op_code,
  input  logic [15:0] a_in,
  input  logic [15:0] b_in,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [15:0] result,
  output logic        overflow,
  output logic        zero,
  output logic        err
);

  localparam logic [3:0]       CNT_LAST = 4'(MUL_CYCLES - 1);
  localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);
  localparam logic [WIDTH-1:0] SMIN     = {1'b1, {(WIDTH-1){1'b0}}};

  state_e           state, state_n;
  logic [2:0]       opc;
  logic [WIDTH-1:0] a_r, b_r, nb_r;
  logic [WIDTH-1:0] acc, mcand, mplier;
  logic [3:0]       cnt;
  logic             lost, ovf_acc;

  logic [WIDTH-1:0] x, y, sum, res_d;
  logic             cout, mul_ovf, load, ovf_d, err_d;

  add16bits adder_u (
    .a   (x),
    .b   (y),
    .sum (sum)
  );

  // Operand mux kept in its own process so the adder path has no false combinational loop.
  always_comb begin
    x = '0;
    y = '0;
    case (state)
      ST_EXEC: begin
        case (opc)
          OP_ADD: begin x = a_r;  y = b_r; end
          OP_SUB: begin x = ~b_r; y = ONE; end
          OP_NEG: begin x = ~a_r; y = ONE; end
          OP_ABS: begin
            if (a_r[WIDTH-1]) begin x = ~a_r; y = ONE; end
            else              begin x = a_r;  y = '0;  end
          end
          default: ;
        endcase
      end
      ST_EXEC2: begin x = a_r; y = nb_r;  end
      ST_MUL:   begin x = acc; y = mcand; end
      default:  ;
    endcase
  end

  assign cout    = (x[WIDTH-1] & y[WIDTH-1]) |
                   ((x[WIDTH-1] | y[WIDTH-1]) & ~sum[WIDTH-1]);
  assign mul_ovf = ovf_acc | (mplier[0] & (cout | lost));

  always_comb begin
    state_n = state;
    load    = 1'b0;
    res_d   = '0;
    ovf_d   = 1'b0;
    err_d   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (op_valid) state_n = (op_code == OP_MUL) ? ST_MUL : ST_EXEC;
      end
      ST_EXEC: begin
        if (opc == OP_SUB) begin
          state_n = ST_EXEC2;
        end else begin
          state_n = ST_DONE;
          load    = 1'b1;
          case (opc)
            OP_ADD: begin
              res_d = sum;
              ovf_d = (a_r[WIDTH-1] == b_r[WIDTH-1]) && (sum[WIDTH-1] != a_r[WIDTH-1]);
            end
            OP_NEG, OP_ABS: begin
              res_d = sum;
              ovf_d = (a_r == SMIN);
            end
            default: err_d = 1'b1;
          endcase
        end
      end
      ST_EXEC2: begin
        state_n = ST_DONE;
        load    = 1'b1;
        res_d   = sum;
        // Judged against the original b so that b = 0x8000 is flagged correctly.
        ovf_d   = (a_r[WIDTH-1] != b_r[WIDTH-1]) && (sum[WIDTH-1] != a_r[WIDTH-1]);
      end
      ST_MUL: begin
        if (cnt == CNT_LAST) begin
          state_n = ST_DONE;
          load    = 1'b1;
          res_d   = mplier[0] ? sum : acc;
          ovf_d   = mul_ovf;
        end
      end
      ST_DONE: begin
        if (res_ready) state_n = ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      opc      <= '0;
      a_r      <= '0;
      b_r      <= '0;
      nb_r     <= '0;
      acc      <= '0;
      mcand    <= '0;
      mplier   <= '0;
      cnt      <= '0;
      lost     <= 1'b0;
      ovf_acc  <= 1'b0;
      result   <= '0;
      overflow <= 1'b0;
      zero     <= 1'b0;
      err      <= 1'b0;
    end else begin
      state <= state_n;
      case (state)
        ST_IDLE: begin
          if (op_valid) begin
            opc     <= op_code;
            a_r     <= a_in;
            b_r     <= b_in;
            acc     <= '0;
            mcand   <= a_in;
            mplier  <= b_in;
            cnt     <= '0;
            lost    <= 1'b0;
            ovf_acc <= 1'b0;
          end
        end
        ST_EXEC: begin
          if (opc == OP_SUB) nb_r <= sum;
        end
        ST_MUL: begin
          if (mplier[0]) acc <= sum;
          mcand   <= mcand << 1;
          mplier  <= mplier >> 1;
          lost    <= lost | mcand[WIDTH-1];
          ovf_acc <= mul_ovf;
          cnt     <= cnt + 4'd1;
        end
        default: ;
      endcase
      if (load) begin
        result   <= res_d;
        overflow <= ovf_d;
        zero     <= (res_d == '0);
        err      <= err_d;
      end
    end
  end

  assign op_ready  = (state == ST_IDLE);
  assign res_valid = (state == ST_DONE);

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Directed-vector bench for alu_seq_ctrl with hand-computed expected results.
module tb_alu_seq_ctrl;

  localparam logic [2:0] C_ADD = 3'b000;
  localparam logic [2:0] C_SUB = 3'b001;
  localparam logic [2:0] C_NEG = 3'b010;
  localparam logic [2:0] C_ABS = 3'b011;
  localparam logic [2:0] C_MUL = 3'b100;
  localparam logic [2:0] C_ILL = 3'b111;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        op_valid;
  logic        op_ready;
  logic [2:0]  op_code;
  logic [15:0] a_in;
  logic [15:0] b_in;
  logic        res_valid;
  logic        res_ready;
  logic [15:0] result;
  logic        overflow;
  logic        zero;
  logic        err;

  int n_asserts = 0;
  int n_fail    = 0;

  alu_seq_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .op_valid  (op_valid),
    .op_ready  (op_ready),
    .op_code   (op_code),
    .a_in      (a_in),
    .b_in      (b_in),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .result    (result),
    .overflow  (overflow),
    .zero      (zero),
    .err       (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called at the negedge right after the accept edge; counts edges until res_valid.
  task automatic wait_result(input string tag, input int lat, input logic [15:0] er,
                             input logic eo, input logic ez, input logic ee);
    int n;
    n = 1;
    while (!res_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_latency"}, n, lat);
    check({tag, "_res_valid"}, res_valid, 1);
    check({tag, "_result"}, result, er);
    check({tag, "_overflow"}, overflow, eo);
    check({tag, "_zero"}, zero, ez);
    check({tag, "_err"}, err, ee);
  endtask

  task automatic run_op(input string tag, input logic [2:0] code, input logic [15:0] a,
                        input logic [15:0] b, input int lat, input logic [15:0] er,
                        input logic eo, input logic ez, input logic ee, input bit consume);
    @(negedge clk);
    op_valid = 1'b1;
    op_code  = code;
    a_in     = a;
    b_in     = b;
    check({tag, "_op_ready"}, op_ready, 1);
    @(posedge clk);
    @(negedge clk);
    op_valid = 1'b0;
    a_in     = 16'hDEAD;
    b_in     = 16'hBEEF;
    wait_result(tag, lat, er, eo, ez, ee);
    if (consume) begin
      res_ready = 1'b1;
      @(negedge clk);
      res_ready = 1'b0;
      check({tag, "_back_idle"}, op_ready, 1);
      check({tag, "_valid_drop"}, res_valid, 0);
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    op_valid  = 1'b0;
    op_code   = '0;
    a_in      = '0;
    b_in      = '0;
    res_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_op_ready", op_ready, 1);
    check("rst_res_valid", res_valid, 0);
    check("rst_result", result, 16'h0000);
    check("rst_flags", {overflow, zero, err}, 3'b000);
    rst_n = 1'b1;

    run_op("add_ovf",  C_ADD, 16'h7FFF, 16'h0001,  2, 16'h8000, 1, 0, 0, 1);
    run_op("add_wrap", C_ADD, 16'hFFFF, 16'h0001,  2, 16'h0000, 0, 1, 0, 1);
    run_op("sub_neg",  C_SUB, 16'h0005, 16'h0007,  3, 16'hFFFE, 0, 0, 0, 1);
    run_op("sub_ovf",  C_SUB, 16'h8000, 16'h0001,  3, 16'h7FFF, 1, 0, 0, 1);
    run_op("sub_min",  C_SUB, 16'h0000, 16'h8000,  3, 16'h8000, 1, 0, 0, 1);
    run_op("neg_min",  C_NEG, 16'h8000, 16'h1234,  2, 16'h8000, 1, 0, 0, 1);
    run_op("abs_neg",  C_ABS, 16'hFFFB, 16'h0000,  2, 16'h0005, 0, 0, 0, 1);
    run_op("abs_pos",  C_ABS, 16'h0123, 16'hFFFF,  2, 16'h0123, 0, 0, 0, 1);
    run_op("abs_min",  C_ABS, 16'h8000, 16'h0000,  2, 16'h8000, 1, 0, 0, 1);
    run_op("neg_zero", C_NEG, 16'h0000, 16'h0000,  2, 16'h0000, 0, 1, 0, 1);
    run_op("illegal",  C_ILL, 16'h1111, 16'h2222,  2, 16'h0000, 0, 1, 1, 1);
    run_op("err_clr",  C_ADD, 16'h0002, 16'h0003,  2, 16'h0005, 0, 0, 0, 1);
    run_op("mul_ffff", C_MUL, 16'h00FF, 16'h0101, 17, 16'hFFFF, 0, 0, 0, 1);
    run_op("mul_ovf",  C_MUL, 16'h0100, 16'h0100, 17, 16'h0000, 1, 1, 0, 1);
    run_op("mul_small",C_MUL, 16'h0003, 16'h0005, 17, 16'h000F, 0, 0, 0, 1);
    run_op("mul_cout", C_MUL, 16'h8000, 16'h0003, 17, 16'h8000, 1, 0, 0, 1);

    // Backpressure: result held, second request ignored until handshake.
    run_op("add_bp",   C_ADD, 16'h1234, 16'h1111,  2, 16'h2345, 0, 0, 0, 0);
    @(negedge clk);
    op_valid = 1'b1;
    op_code  = C_SUB;
    a_in     = 16'h0009;
    b_in     = 16'h0001;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_result", result, 16'h2345);
      check("bp_op_ready", op_ready, 0);
      check("bp_res_valid", res_valid, 1);
    end
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    check("bp_idle", op_ready, 1);
    check("bp_valid_drop", res_valid, 0);
    @(posedge clk);
    @(negedge clk);
    op_valid = 1'b0;
    wait_result("bp_second", 3, 16'h0008, 0, 0, 0);
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;

    // Leave err set, then abort a MUL part-way through with reset.
    run_op("ill2", C_ILL, 16'h0000, 16'h0000, 2, 16'h0000, 0, 1, 1, 1);
    @(negedge clk);
    op_valid = 1'b1;
    op_code  = C_MUL;
    a_in     = 16'h1234;
    b_in     = 16'hFFFF;
    @(posedge clk);
    @(negedge clk);
    op_valid = 1'b0;
    repeat (7) @(negedge clk);
    check("mul_busy_ready", op_ready, 0);
    check("mul_busy_valid", res_valid, 0);
    check("mul_busy_err", err, 1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("abort_op_ready", op_ready, 1);
    check("abort_res_valid", res_valid, 0);
    check("abort_result", result, 16'h0000);
    check("abort_flags", {overflow, zero, err}, 3'b000);
    run_op("post_abort", C_ADD, 16'h0001, 16'h0002, 2, 16'h0003, 0, 0, 0, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
